fp_square_pipeline: RTL and testbench

- Fully pipelined IEEE-754 binary32 squaring unit (out = in*in), the inverse operation of fp_sqrt_pipeline.
- Same port contract and flag set as the sqrt unit, so benches and ALU muxing treat both units identically.
- Used by the ALU for the square op and as a round-trip checker for sqrt results in regression.

---
 rtl/fp_square_pipeline.sv | 242 ++++++++++++++++++++++++
 tb/tb_fp_square_pipeline.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_square_pipeline.sv
// Fully pipelined IEEE-754 binary32 squaring unit (out = in*in), fixed latency of 4 cycles.
// Shares its port contract and flag set with fp_sqrt_pipeline so the two are interchangeable.
module fp_square_pipeline (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_data_in,
    input  logic [31:0] in,
    input  logic [2:0]  rounding_mode,
    output logic [31:0] out,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact,
    output logic        invalid_operation,
    output logic        valid_data_out
);

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] MAX_FIN = 32'h7F7F_FFFF;

    function automatic logic [4:0] lzc23(input logic [22:0] v);
        lzc23 = 5'd23;
        for (int i = 0; i < 23; i++) begin
            if (v[i]) lzc23 = 5'(22 - i);
        end
    endfunction

    // Operand capture register
    logic        r0_valid;
    logic [31:0] r0_in;
    logic [2:0]  r0_rm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r0_valid <= 1'b0;
        end else begin
            r0_valid <= valid_data_in;
        end
        r0_in <= in;
        r0_rm <= rounding_mode;
    end

    // Stage 1: classify and normalise subnormals into a 24-bit significand
    logic [7:0]         c1_exp;
    logic [22:0]        c1_man;
    logic [4:0]         c1_lz;
    logic               c1_special;
    logic [31:0]        c1_spec_val;
    logic               c1_inv;
    logic [23:0]        c1_sig;
    logic signed [9:0]  c1_e;

    always_comb begin
        c1_exp      = r0_in[30:23];
        c1_man      = r0_in[22:0];
        c1_lz       = lzc23(c1_man);
        c1_special  = 1'b0;
        c1_spec_val = 32'h0;
        c1_inv      = 1'b0;
        c1_sig      = 24'h0;
        c1_e        = 10'sd0;
        if (c1_exp == 8'hFF) begin
            c1_special = 1'b1;
            if (c1_man != 23'h0) begin
                c1_spec_val = QNAN;
                c1_inv      = ~c1_man[22];
            end else begin
                c1_spec_val = POS_INF;
            end
        end else if (c1_exp == 8'h00 && c1_man == 23'h0) begin
            c1_special  = 1'b1;
            c1_spec_val = 32'h0;
        end else if (c1_exp == 8'h00) begin
            c1_sig = {1'b0, c1_man} << (c1_lz + 5'd1);
            c1_e   = -10'sd127 - $signed({5'b0, c1_lz});
        end else begin
            c1_sig = {1'b1, c1_man};
            c1_e   = $signed({2'b0, c1_exp}) - 10'sd127;
        end
    end

    logic               s1_valid;
    logic [2:0]         s1_rm;
    logic               s1_special;
    logic [31:0]        s1_spec_val;
    logic               s1_inv;
    logic [23:0]        s1_sig;
    logic signed [9:0]  s1_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= r0_valid;
        end
        s1_rm       <= r0_rm;
        s1_special  <= c1_special;
        s1_spec_val <= c1_spec_val;
        s1_inv      <= c1_inv;
        s1_sig      <= c1_sig;
        s1_e        <= c1_e;
    end

    // Stage 2: significand square and doubled exponent
    logic               s2_valid;
    logic [2:0]         s2_rm;
    logic               s2_special;
    logic [31:0]        s2_spec_val;
    logic               s2_inv;
    logic [47:0]        s2_prod;
    logic signed [10:0] s2_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
        s2_rm       <= s1_rm;
        s2_special  <= s1_special;
        s2_spec_val <= s1_spec_val;
        s2_inv      <= s1_inv;
        s2_prod     <= {24'h0, s1_sig} * {24'h0, s1_sig};
        s2_e        <= $signed({s1_e, 1'b0});
    end

    // Stage 3: align leading one to bit 47, then denormalise tiny results with sticky collection
    logic [47:0]        c3_prod_n;
    logic signed [10:0] c3_be;
    logic signed [10:0] c3_sh_full;
    logic [4:0]         c3_sh;
    logic               c3_tiny;
    logic [73:0]        c3_ext;

    always_comb begin
        c3_prod_n  = s2_prod[47] ? s2_prod : {s2_prod[46:0], 1'b0};
        c3_be      = s2_e + (s2_prod[47] ? 11'sd128 : 11'sd127);
        c3_tiny    = (c3_be < 11'sd1);
        c3_sh_full = 11'sd1 - c3_be;
        c3_sh      = 5'd0;
        if (c3_tiny) begin
            c3_sh = (c3_sh_full > 11'sd26) ? 5'd26 : c3_sh_full[4:0];
        end
        c3_ext = {c3_prod_n, 26'h0} >> c3_sh;
    end

    logic               s3_valid;
    logic [2:0]         s3_rm;
    logic               s3_special;
    logic [31:0]        s3_spec_val;
    logic               s3_inv;
    logic signed [10:0] s3_exp;
    logic [22:0]        s3_mant;
    logic               s3_g;
    logic               s3_r;
    logic               s3_s;
    logic               s3_tiny;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
        end
        s3_rm       <= s2_rm;
        s3_special  <= s2_special;
        s3_spec_val <= s2_spec_val;
        s3_inv      <= s2_inv;
        s3_exp      <= c3_tiny ? 11'sd0 : c3_be;
        s3_mant     <= c3_ext[72:50];
        s3_g        <= c3_ext[49];
        s3_r        <= c3_ext[48];
        s3_s        <= |c3_ext[47:0];
        s3_tiny     <= c3_tiny;
    end

    // Stage 4: round (result is never negative, so RDN behaves as truncation) and pack
    logic               c4_up;
    logic [23:0]        c4_sum;
    logic signed [10:0] c4_exp;
    logic               c4_lost;
    logic               c4_ovf;
    logic [31:0]        c4_out;
    logic               c4_unf;
    logic               c4_inx;
    logic               c4_inv;

    always_comb begin
        case (s3_rm)
            RM_RTZ, RM_RDN: c4_up = 1'b0;
            RM_RUP:         c4_up = s3_g | s3_r | s3_s;
            RM_RMM:         c4_up = s3_g;
            default:        c4_up = s3_g & (s3_r | s3_s | s3_mant[0]);
        endcase
        c4_sum  = {1'b0, s3_mant} + {23'h0, c4_up};
        c4_exp  = s3_exp + $signed({10'h0, c4_sum[23]});
        c4_lost = s3_g | s3_r | s3_s;
        c4_ovf  = (c4_exp >= 11'sd255);
        c4_out  = {1'b0, c4_exp[7:0], c4_sum[22:0]};
        c4_unf  = s3_tiny & c4_lost;
        c4_inx  = c4_lost;
        c4_inv  = 1'b0;
        if (s3_special) begin
            c4_out = s3_spec_val;
            c4_ovf = 1'b0;
            c4_unf = 1'b0;
            c4_inx = 1'b0;
            c4_inv = s3_inv;
        end else if (c4_ovf) begin
            c4_out = (s3_rm == RM_RTZ || s3_rm == RM_RDN) ? MAX_FIN : POS_INF;
            c4_inx = 1'b1;
            c4_unf = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_data_out    <= 1'b0;
            out               <= 32'h0;
            overflow          <= 1'b0;
            underflow         <= 1'b0;
            inexact           <= 1'b0;
            invalid_operation <= 1'b0;
        end else begin
            valid_data_out <= s3_valid;
            if (s3_valid) begin
                out               <= c4_out;
                overflow          <= c4_ovf;
                underflow         <= c4_unf;
                inexact           <= c4_inx;
                invalid_operation <= c4_inv;
            end
        end
    end

endmodule

// File: tb/tb_fp_square_pipeline.sv
// Directed self-checking bench for fp_square_pipeline: hand-computed squares, rounding, specials, streaming, reset.
module tb_fp_square_pipeline;

    logic        clk;
    logic        rst;
    logic        valid_data_in;
    logic [31:0] in;
    logic [2:0]  rounding_mode;
    logic [31:0] out;
    logic        overflow;
    logic        underflow;
    logic        inexact;
    logic        invalid_operation;
    logic        valid_data_out;

    int n_checks = 0;
    int n_fail   = 0;

    fp_square_pipeline dut (
        .clk               (clk),
        .rst               (rst),
        .valid_data_in     (valid_data_in),
        .in                (in),
        .rounding_mode     (rounding_mode),
        .out               (out),
        .overflow          (overflow),
        .underflow         (underflow),
        .inexact           (inexact),
        .invalid_operation (invalid_operation),
        .valid_data_out    (valid_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operand for a single cycle and waits (bounded) for its result; lat is edges after sampling.
    task automatic issue_op(input logic [31:0] op, input logic [2:0] rm,
                            output logic [31:0] o, output logic [3:0] f, output int lat);
        @(negedge clk);
        in            = op;
        rounding_mode = rm;
        valid_data_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_data_in = 1'b0;
        lat = -1;
        o   = 32'h0;
        f   = 4'h0;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (valid_data_out) begin
                lat = k;
                o   = out;
                f   = {overflow, underflow, inexact, invalid_operation};
            end
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        valid_data_in = 1'b0;
        in            = 32'h0;
        rounding_mode = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (valid_data_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_valid got=%b want=0", valid_data_out);
        end
        n_checks++;
        if ({out, overflow, underflow, inexact, invalid_operation} !== 36'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs got out=%h flags=%b%b%b%b want 0",
                     out, overflow, underflow, inexact, invalid_operation);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Table-driven single-operand cases; flags packed as {ovf,unf,inx,inv}
    task automatic test_single_ops();
        logic [31:0] ops  [17];
        logic [2:0]  rms  [17];
        logic [31:0] exps [17];
        logic [3:0]  expf [17];
        logic [31:0] o;
        logic [3:0]  f;
        int          lat;
        ops = '{32'h4040_0000, 32'hBFC0_0000, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0001,
                32'h3F80_0001, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h1F80_0000,
                32'h0000_0001, 32'h0000_0001, 32'h7FA0_0000, 32'h7FC0_0001, 32'hFF80_0000,
                32'h8000_0000, 32'h7F7F_FFFF};
        rms = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd1, 3'd5, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd3,
                3'd0, 3'd0, 3'd0, 3'd0, 3'd4};
        exps = '{32'h4110_0000, 32'h4010_0000, 32'h3F80_0002, 32'h3F80_0003, 32'h3F80_0002,
                 32'h3F80_0002, 32'h7F80_0000, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h0020_0000,
                 32'h0000_0000, 32'h0000_0001, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7F80_0000,
                 32'h0000_0000, 32'h7F80_0000};
        expf = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1010, 4'b1010,
                 4'b1010, 4'b0000, 4'b0110, 4'b0110, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
                 4'b1010};
        for (int i = 0; i < 17; i++) begin
            issue_op(ops[i], rms[i], o, f, lat);
            n_checks++;
            if (lat != 4) begin
                n_fail++;
                $display("[TB] FAIL latency[%0d] in=%h got=%0d want=4", i, ops[i], lat);
            end
            n_checks++;
            if (o !== exps[i]) begin
                n_fail++;
                $display("[TB] FAIL result[%0d] in=%h rm=%0d got=%h want=%h", i, ops[i], rms[i], o, exps[i]);
            end
            n_checks++;
            if (f !== expf[i]) begin
                n_fail++;
                $display("[TB] FAIL flags[%0d] in=%h rm=%0d got=%b want=%b", i, ops[i], rms[i], f, expf[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops  [3];
        logic [31:0] exps [3];
        logic [31:0] got  [3];
        int          edge_at [3];
        int          n_seen;
        ops  = '{32'h4040_0000, 32'hBFC0_0000, 32'h3F80_0001};
        exps = '{32'h4110_0000, 32'h4010_0000, 32'h3F80_0002};
        got     = '{32'h0, 32'h0, 32'h0};
        edge_at = '{-1, -1, -1};
        n_seen  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in            = ops[i];
            rounding_mode = 3'd0;
            valid_data_in = 1'b1;
        end
        @(negedge clk);
        valid_data_in = 1'b0;
        for (int k = 3; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (valid_data_out) begin
                if (n_seen < 3) begin
                    got[n_seen]     = out;
                    edge_at[n_seen] = k;
                end
                n_seen++;
            end
        end
        n_checks++;
        if (n_seen != 3) begin
            n_fail++;
            $display("[TB] FAIL stream_count got=%0d want=3", n_seen);
        end
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (edge_at[j] != 4 + j || got[j] !== exps[j]) begin
                n_fail++;
                $display("[TB] FAIL stream[%0d] got edge=%0d out=%h want edge=%0d out=%h",
                         j, edge_at[j], got[j], 4 + j, exps[j]);
            end
        end
    endtask

    task automatic test_reset_mid_flight();
        logic [31:0] ops [3];
        int          seen;
        ops  = '{32'h4040_0000, 32'hBFC0_0000, 32'h3F80_0001};
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in            = ops[i];
            rounding_mode = 3'd0;
            valid_data_in = 1'b1;
            if (i == 2) rst = 1'b1;
        end
        @(negedge clk);
        valid_data_in = 1'b0;
        rst           = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (valid_data_out) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("[TB] FAIL flush_valid got=%0d valid cycles want=0", seen);
        end
        n_checks++;
        if ({out, overflow, underflow, inexact, invalid_operation} !== 36'h0) begin
            n_fail++;
            $display("[TB] FAIL flush_outputs got out=%h flags=%b%b%b%b want 0",
                     out, overflow, underflow, inexact, invalid_operation);
        end
    endtask

    initial begin
        $display("[TB] starting fp_square_pipeline bench");
        test_reset();
        test_single_ops();
        test_back_to_back();
        test_reset_mid_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
